// File: rtl/balance_control.sv
// PID pitch-balance controller: saturated pitch error drives P/I/D terms, summed and
// split into left/right torques with optional steering, then shaped into motor commands.
module balance_shape #(
  parameter logic [7:0]  LOW_TORQUE_BAND = 8'h46,
  parameter logic [5:0]  GAIN_MULTIPLIER = 6'h0F,
  parameter logic [14:0] MIN_DUTY        = 15'h03D4
) (
  input  logic signed [15:0] torque,
  output logic        [10:0] spd,
  output logic               rev
);
  logic [15:0]        abs_t;
  logic signed [15:0] shaped;
  logic [15:0]        mag;

  always_comb begin
    abs_t = torque[15] ? 16'(-torque) : 16'(torque);
    // Small torques get boosted gain to overcome stiction; larger ones get a duty floor.
    if (abs_t < 16'(LOW_TORQUE_BAND))
      shaped = torque * $signed({10'd0, GAIN_MULTIPLIER});
    else if (!torque[15])
      shaped = torque + $signed({1'b0, MIN_DUTY});
    else
      shaped = torque - $signed({1'b0, MIN_DUTY});
    mag = shaped[15] ? 16'(-shaped) : 16'(shaped);
    rev = shaped[15];
    spd = (mag > 16'd2047) ? 11'h7FF : mag[10:0];
  end
endmodule

module balance_control #(
  parameter logic [4:0]  P_COEFF         = 5'h0E,
  parameter logic [5:0]  D_COEFF         = 6'h14,
  parameter logic [7:0]  LOW_TORQUE_BAND = 8'h46,
  parameter logic [5:0]  GAIN_MULTIPLIER = 6'h0F,
  parameter logic [14:0] MIN_DUTY        = 15'h03D4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic [15:0] ptch,
  input  logic [11:0] ld_cell_diff,
  input  logic        rider_off,
  input  logic        en_steer,
  output logic [10:0] lft_spd,
  output logic        lft_rev,
  output logic [10:0] rght_spd,
  output logic        rght_rev
);
  localparam int NUM_LANES = 2;

  logic signed [9:0]  err_sat;
  logic signed [14:0] p_term;
  logic signed [17:0] integ, err_ext, sum;
  logic               ovf;
  logic signed [11:0] i_term;
  logic signed [9:0]  q1, q2, d_diff;
  logic signed [6:0]  d_sat;
  logic signed [12:0] d_term;
  logic signed [15:0] pid, steer;
  logic [NUM_LANES-1:0][15:0] torque;
  logic [NUM_LANES-1:0][10:0] spd;
  logic [NUM_LANES-1:0]       rev;

  always_comb begin
    if ($signed(ptch) > 16'sd511)       err_sat = 10'sh1FF;
    else if ($signed(ptch) < -16'sd512) err_sat = 10'sh200;
    else                                err_sat = $signed(ptch[9:0]);
  end

  assign p_term  = 15'(err_sat) * $signed({10'd0, P_COEFF});
  assign err_ext = 18'(err_sat);
  assign sum     = integ + err_ext;
  // Same-sign operands producing an opposite-sign sum means the add wrapped.
  assign ovf     = (integ[17] == err_ext[17]) && (sum[17] != integ[17]);
  assign i_term  = integ[17:6];

  assign d_diff = err_sat - q2;
  always_comb begin
    if (d_diff > 10'sd63)       d_sat = 7'sd63;
    else if (d_diff < -10'sd64) d_sat = -7'sd64;
    else                        d_sat = d_diff[6:0];
  end
  assign d_term = 13'(d_sat) * $signed({7'd0, D_COEFF});

  assign pid   = 16'(p_term) + 16'(i_term) + 16'(d_term);
  assign steer = 16'($signed(ld_cell_diff) >>> 3);

  assign torque[0] = en_steer ? 16'(pid - steer) : 16'(pid);
  assign torque[1] = en_steer ? 16'(pid + steer) : 16'(pid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      integ <= '0;
      q1    <= '0;
      q2    <= '0;
    end else begin
      if (rider_off)     integ <= '0;
      else if (vld && !ovf) integ <= sum;
      if (vld) begin
        q1 <= err_sat;
        q2 <= q1;
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    balance_shape #(
      .LOW_TORQUE_BAND(LOW_TORQUE_BAND),
      .GAIN_MULTIPLIER(GAIN_MULTIPLIER),
      .MIN_DUTY       (MIN_DUTY)
    ) u_shape (
      .torque(torque[g]),
      .spd   (spd[g]),
      .rev   (rev[g])
    );
  end

  assign lft_spd  = spd[0];
  assign lft_rev  = rev[0];
  assign rght_spd = spd[1];
  assign rght_rev = rev[1];
endmodule

// File: tb/tb_balance_control.sv
// Randomized bench for balance_control against an integer-arithmetic reference model.
module tb_balance_control;
  logic        clk = 1'b0;
  logic        rst_n, vld, rider_off, en_steer;
  logic [15:0] ptch;
  logic [11:0] ld_cell_diff;
  logic [10:0] lft_spd, rght_spd;
  logic        lft_rev, rght_rev;

  int n_tests = 0, n_fail = 0;
  int m_integ = 0, m_q1 = 0, m_q2 = 0;

  always #5 clk = ~clk;

  balance_control dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .ptch(ptch), .ld_cell_diff(ld_cell_diff),
    .rider_off(rider_off), .en_steer(en_steer), .lft_spd(lft_spd), .lft_rev(lft_rev),
    .rght_spd(rght_spd), .rght_rev(rght_rev)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (ptch=%0d t=%0t)", tag, obs, exp, $signed(ptch), $time);
    end
  endtask

  function automatic int sat(input int v, input int lo, input int hi);
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  function automatic int err_of(input logic [15:0] p);
    int pv;
    pv = $signed(p);
    return sat(pv, -512, 511);
  endfunction

  function automatic void shape(input int t, output int spd, output int rev);
    int s, a;
    a = (t < 0) ? -t : t;
    if (a < 70)      s = t * 15;
    else if (t >= 0) s = t + 980;
    else             s = t - 980;
    rev = (s < 0) ? 1 : 0;
    a = (s < 0) ? -s : s;
    spd = (a > 2047) ? 2047 : a;
  endfunction

  task automatic check_model(input string tag);
    int e, dd, pid, s, lv, ls, lr, rs, rr;
    e  = err_of(ptch);
    dd = e - m_q2;
    if (dd > 511) dd -= 1024;
    else if (dd < -512) dd += 1024;
    pid = e * 14 + (m_integ >>> 6) + sat(dd, -64, 63) * 20;
    lv  = $signed(ld_cell_diff);
    s   = en_steer ? (lv >>> 3) : 0;
    shape(pid - s, ls, lr);
    shape(pid + s, rs, rr);
    chk({tag, ".lspd"}, int'(lft_spd), ls);
    chk({tag, ".lrev"}, int'(lft_rev), lr);
    chk({tag, ".rspd"}, int'(rght_spd), rs);
    chk({tag, ".rrev"}, int'(rght_rev), rr);
  endtask

  task automatic drive(input logic r, input logic v, input logic [15:0] p,
                       input logic [11:0] l, input logic ro, input logic es);
    @(negedge clk);
    rst_n = r; vld = v; ptch = p; ld_cell_diff = l; rider_off = ro; en_steer = es;
    #1;
  endtask

  task automatic tick();
    int e, sum;
    @(posedge clk);
    e = err_of(ptch);
    if (!rst_n) begin
      m_integ = 0; m_q1 = 0; m_q2 = 0;
    end else begin
      if (rider_off) m_integ = 0;
      else if (vld) begin
        sum = m_integ + e;
        if (sum <= 131071 && sum >= -131072) m_integ = sum;
      end
      if (vld) begin
        m_q2 = m_q1;
        m_q1 = e;
      end
    end
  endtask

  task automatic step(input string tag, input logic r, input logic v, input logic [15:0] p,
                      input logic [11:0] l, input logic ro, input logic es);
    drive(r, v, p, l, ro, es);
    check_model(tag);
    tick();
  endtask

  task automatic do_reset();
    step("rst", 1'b0, 1'b0, 16'h0, 12'h0, 1'b0, 1'b0);
    step("rst", 1'b0, 1'b0, 16'h0, 12'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] p;
    logic [11:0] l;
    do_reset();
    drive(1'b1, 1'b0, 16'h0, 12'h0, 1'b0, 1'b0);
    chk("reset.lspd", int'(lft_spd), 0);
    chk("reset.rspd", int'(rght_spd), 0);
    chk("reset.rev", int'({lft_rev, rght_rev}), 0);
    tick();

    // Low-torque P+D: 28 + 40 = 68, scaled by 15.
    drive(1'b1, 1'b1, 16'd2, 12'h0, 1'b0, 1'b0);
    chk("lowtq.lspd", int'(lft_spd), 1020);
    chk("lowtq.rspd", int'(rght_spd), 1020);
    chk("lowtq.lrev", int'(lft_rev), 0);
    check_model("lowtq");
    tick();

    do_reset();
    drive(1'b1, 1'b1, 16'd6, 12'h0, 1'b0, 1'b0);
    chk("hitq.spd", int'(lft_spd), 1184);
    tick();
    do_reset();
    drive(1'b1, 1'b1, 16'hFFFA, 12'h0, 1'b0, 1'b0);
    chk("hitq_neg.spd", int'(rght_spd), 1184);
    chk("hitq_neg.rev", int'(rght_rev), 1);
    tick();
    do_reset();
    drive(1'b1, 1'b1, 16'd6, 12'd150, 1'b0, 1'b1);
    chk("steer.lspd", int'(lft_spd), 1166);
    chk("steer.rspd", int'(rght_spd), 1202);
    tick();

    // Positive windup to the overflow hold, then a clear.
    do_reset();
    for (int i = 0; i < 300; i++) step("winduppos", 1'b1, 1'b1, 16'h01FF, 12'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 16'h01FF, 12'h0, 1'b0, 1'b0);
    chk("winduppos.spd", int'(lft_spd), 2047);
    chk("winduppos.rev", int'(lft_rev), 0);
    tick();
    step("clear", 1'b1, 1'b1, 16'h0, 12'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("postclr", 1'b1, 1'b0, 16'h0, 12'h0, 1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < 300; i++) step("windupneg", 1'b1, 1'b1, 16'hFE01, 12'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 16'hFE01, 12'h0, 1'b0, 1'b0);
    chk("windupneg.spd", int'(lft_spd), 2047);
    chk("windupneg.rev", int'(lft_rev), 1);
    tick();

    do_reset();
    for (int i = 0; i < 128; i++) step("vldtog", 1'b1, i[0], 16'd2, 12'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("sat", 1'b1, 1'b1, 16'h0300, 12'h0, 1'b0, 1'b0);

    // Random mix, including holds, mid-run resets and rider_off pulses.
    p = 16'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 3))
          0: p = 16'($urandom_range(0, 24)) - 16'd12;
          1: p = 16'($urandom_range(0, 160)) - 16'd80;
          2: p = 16'($urandom_range(0, 1400)) - 16'd700;
          default: p = 16'($urandom);
        endcase
      end
      l = ($urandom_range(0, 1) != 0) ? 12'($urandom) : 12'($urandom_range(0, 64)) - 12'd32;
      step("rand", ($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 7), p, l,
           ($urandom_range(0, 19) == 0), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
